multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 opcode input 6: instruction[31:26] from the external instruction register, stable from DECODE onward.
REQ-003 mem_ready input 1: memory completes the current read or write this cycle.
REQ-004 pc_write output 1, pc_write_cond output 1 (write PC if ALU zero), pc_source output 2 (00 ALU, 01 ALUOut, 10 jump target).
REQ-005 i_or_d output 1 (0 = PC address, 1 = ALUOut address); mem_read output 1; mem_write output 1; ir_write output 1.
REQ-006 reg_dst output 1; mem_2_reg output 1; reg_write output 1.
REQ-007 alu_src_a output 1 (0 = PC, 1 = rs); alu_src_b output 2 (00 rt, 01 const 4, 10 sign-extended imm, 11 imm<<2); alu_op output 2 (00 add, 01 sub, 10 funct).
REQ-008 state output 4: current state code; illegal_op output 1: one-cycle pulse on an unsupported opcode.

Function
REQ-009 The block SHALL be a Moore FSM with a registered 4-bit state: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11. Codes 12-15 SHALL go to FETCH.
REQ-010 Every output not listed for a state SHALL be 0.
REQ-011 FETCH SHALL drive mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
- ir_write=1 and pc_write=1 only in the cycle mem_ready=1.
- Advance to DECODE on mem_ready=1; otherwise stay.
REQ-012 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=00, then branch on opcode:
- 0x23/0x2B -> MEM_ADDR; 0x00 -> EXEC; 0x04 -> BRANCH; 0x02 -> JUMP; 0x08 -> ADDI_EX.
- Any other opcode -> FETCH with illegal_op=1 for that DECODE cycle.
REQ-013 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00; next state MEM_RD if opcode=0x23, else MEM_WR.
REQ-014 MEM_RD SHALL drive mem_read=1, i_or_d=1; it SHALL hold until mem_ready=1, then go to MEM_WB.
REQ-015 MEM_WB SHALL drive reg_write=1, mem_2_reg=1, reg_dst=0; next state FETCH.
REQ-016 MEM_WR SHALL drive mem_write=1, i_or_d=1; it SHALL hold until mem_ready=1, then go to FETCH.
REQ-017 EXEC SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10; next state R_WB. R_WB SHALL drive reg_write=1, reg_dst=1; next state FETCH.
REQ-018 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; next state FETCH.
REQ-019 JUMP SHALL drive pc_write=1, pc_source=10; next state FETCH.
REQ-020 ADDI_EX SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00; next state ADDI_WB. ADDI_WB SHALL drive reg_write=1, reg_dst=0, mem_2_reg=0; next state FETCH.
REQ-021 With zero-wait memory, latency in cycles SHALL be: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4, illegal 2.
REQ-022 Each wait cycle SHALL add exactly one cycle. While waiting, mem_read, mem_write and i_or_d SHALL stay constant.
REQ-023 mem_ready SHALL be ignored in every state except FETCH, MEM_RD and MEM_WR.

Reset
REQ-024 While rst=1 at a clock edge, state SHALL load FETCH.
REQ-025 While rst=1, all outputs SHALL be forced to 0 combinationally (state output reads 0).
REQ-026 Reset asserted mid-instruction, including during a memory wait, SHALL abort the instruction. The first cycle after rst deasserts SHALL be FETCH.

Configuration
REQ-027 Macro MULTICYCLE_MEM_WAIT_EN: when defined, REQ-011/014/016/022 apply as written.
REQ-028 When MULTICYCLE_MEM_WAIT_EN is not defined, mem_ready SHALL be ignored and treated as constant 1: every memory state lasts exactly one cycle, and ir_write/pc_write are asserted for the whole FETCH cycle.

Verification
REQ-029 Reset, then opcode=0x00, mem_ready=1 -> states 0,1,6,7,0; reg_write=1, reg_dst=1 only in state 7.
REQ-030 opcode=0x23, mem_ready low for 2 cycles in MEM_RD (macro defined) -> states 0,1,2,3,3,3,4,0; mem_read=1, i_or_d=1 held for all three state-3 cycles.
REQ-031 opcode=0x04 then opcode=0x02 back-to-back -> states 0,1,8,0,1,9,0; pc_write_cond=1, pc_source=01 in 8; pc_write=1, pc_source=10 in 9.
REQ-032 opcode=0x3F -> states 0,1,0; illegal_op=1 only in the DECODE cycle; no reg_write or mem_write.
REQ-033 rst=1 for one edge while in MEM_WR with mem_ready=0 -> all outputs 0 during rst; next state FETCH; no mem_write afterwards until a new sw.
REQ-034 Macro undefined, mem_ready tied 0, opcode=0x2B -> states 0,1,2,5,0; FETCH ir_write=1, pc_write=1.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control unit: Moore FSM sequencing fetch, decode, memory, ALU and writeback.
// Optional memory wait states are enabled by defining MULTICYCLE_MEM_WAIT_EN.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_2_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [3:0] state,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC     = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        ADDI_EX  = 4'd10,
        ADDI_WB  = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    state_t state_r;
    logic   ready_s;

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign ready_s = mem_ready;
`else
    // Zero-wait memory: every memory access completes in its first cycle.
    logic unused_ready_s;
    assign ready_s        = 1'b1;
    assign unused_ready_s = mem_ready;
`endif

    // State register and next-state sequencing; unused codes recover to FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= FETCH;
        end else begin
            case (state_r)
                FETCH:    state_r <= ready_s ? DECODE : FETCH;
                DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state_r <= MEM_ADDR;
                        OP_RTYPE:     state_r <= EXEC;
                        OP_BEQ:       state_r <= BRANCH;
                        OP_J:         state_r <= JUMP;
                        OP_ADDI:      state_r <= ADDI_EX;
                        default:      state_r <= FETCH;
                    endcase
                end
                MEM_ADDR: state_r <= (opcode == OP_LW) ? MEM_RD : MEM_WR;
                MEM_RD:   state_r <= ready_s ? MEM_WB : MEM_RD;
                MEM_WB:   state_r <= FETCH;
                MEM_WR:   state_r <= ready_s ? FETCH : MEM_WR;
                EXEC:     state_r <= R_WB;
                R_WB:     state_r <= FETCH;
                BRANCH:   state_r <= FETCH;
                JUMP:     state_r <= FETCH;
                ADDI_EX:  state_r <= ADDI_WB;
                ADDI_WB:  state_r <= FETCH;
                default:  state_r <= FETCH;
            endcase
        end
    end

    // Output decode from the current state; reset forces every output low immediately.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_2_reg     = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        illegal_op    = 1'b0;
        state         = 4'd0;
        if (rst) begin
            state = 4'd0;
        end else begin
            state = state_r;
            case (state_r)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = ready_s;
                    pc_write  = ready_s;
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
                        default:                                       illegal_op = 1'b1;
                    endcase
                end
                MEM_ADDR, ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                MEM_WB: begin
                    reg_write = 1'b1;
                    mem_2_reg = 1'b1;
                end
                MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                ADDI_WB: begin
                    reg_write = 1'b1;
                end
                default: begin
                    state = state_r;
                end
            endcase
        end
    end

endmodule
